// File: rtl/direction_input_conditioner.sv
// direction_input_conditioner
//
// Front end for the direction decoder. Each raw push-button level is passed
// through a two-flop synchroniser and an independent debouncer. The debounced
// bits drive the decoder select lines directly. A settle counter holds
// `enable` low until the debounced combination has stopped changing for
// SETTLE_CYCLES edges. This hides the intermediate combinations that appear
// while two buttons are pressed slightly apart.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive differing synchronised samples needed before
//                    a debounced bit flips (>= 1)
//   SETTLE_CYCLES    unchanged edges needed before enable asserts (>= 1)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   btn_up     raw button, asynchronous to clk, may bounce
//   btn_left   raw button, asynchronous to clk, may bounce
//   btn_right  raw button, asynchronous to clk, may bounce
//   up         debounced btn_up (decoder select MSB), registered
//   left       debounced btn_left, registered
//   right      debounced btn_right (decoder select LSB), registered
//   enable     high while {up,left,right} has been stable >= SETTLE_CYCLES

module direction_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_left,
  input  logic btn_right,
  output logic up,
  output logic left,
  output logic right,
  output logic enable
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

  // A debounced bit flips on the edge where the count would reach
  // DEBOUNCE_CYCLES, i.e. when the current count is one below it.
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SMAX  = SW'(SETTLE_CYCLES);

  // Bit 2 = up, bit 1 = left, bit 0 = right, matching the decoder select.
  logic [2:0]    raw;
  logic [2:0]    s1_q, s2_q;
  logic [2:0]    deb_q, deb_d;
  logic [DW-1:0] dcnt_q [3];
  logic [DW-1:0] dcnt_d [3];
  logic [SW-1:0] scnt_q, scnt_d;
  logic          en_q, en_d;
  logic          changed;

  assign raw = {btn_up, btn_left, btn_right};

  // Synchroniser chains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // Debouncers: any sample that agrees with the debounced value restarts
  // the count, so bounces shorter than DEBOUNCE_CYCLES never get through.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i]  = deb_q[i];
      dcnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DLAST) begin
          deb_d[i] = s2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q <= '0;
      for (int i = 0; i < 3; i++) begin
        dcnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < 3; i++) begin
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

  // Settle tracking. enable is registered from the next counter value so it
  // drops on the same edge the outputs change and never glitches.
  assign changed = (deb_d != deb_q);

  always_comb begin
    scnt_d = scnt_q;
    if (changed) begin
      scnt_d = '0;
    end else if (scnt_q != SMAX) begin
      scnt_d = scnt_q + SW'(1);
    end
    en_d = (scnt_d == SMAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt_q <= '0;
      en_q   <= 1'b0;
    end else begin
      scnt_q <= scnt_d;
      en_q   <= en_d;
    end
  end

  assign up     = deb_q[2];
  assign left   = deb_q[1];
  assign right  = deb_q[0];
  assign enable = en_q;

endmodule

// File: tb/tb_direction_input_conditioner.sv
// Directed bench for direction_input_conditioner at DEBOUNCE_CYCLES=4,
// SETTLE_CYCLES=8. Inputs change and outputs are sampled 1 time unit after
// each rising edge. A button set there is first sampled at the next edge
// ("edge 0"). After n ticks the bench therefore observes the state following
// edge n-1.

module tb_direction_input_conditioner;

  logic clk;
  logic rst;
  logic btn_up, btn_left, btn_right;
  logic up, left, right, enable;

  int tests;
  int fails;

  direction_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .SETTLE_CYCLES  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .up       (up),
    .left     (left),
    .right    (right),
    .enable   (enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed vector is {up, left, right, enable}.
  task automatic test_reset();
    rst = 1'b1;
    btn_up = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    #2;
    tests++;
    if ({up, left, right, enable} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_assert: got %b want 0000", {up, left, right, enable});
    end
    tick(); tick();
    rst = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      logic [3:0] exp;
      tick();
      exp = {3'b000, n >= 8};
      tests++;
      if ({up, left, right, enable} !== exp) begin
        fails++;
        $display("FAIL reset_idle n=%0d: got %b want %b", n, {up, left, right, enable}, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    btn_up = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      logic [3:0] exp;
      tick();
      exp = {n >= 6, 2'b00, (n < 6) || (n >= 14)};
      tests++;
      if ({up, left, right, enable} !== exp) begin
        fails++;
        $display("FAIL clean_press n=%0d: got %b want %b", n, {up, left, right, enable}, exp);
      end
    end
  endtask

  task automatic test_bounce();
    btn_left = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 3) btn_left = 1'b0;
      tests++;
      if ({up, left, right, enable} !== 4'b1001) begin
        fails++;
        $display("FAIL bounce n=%0d: got %b want 1001", n, {up, left, right, enable});
      end
    end
  endtask

  task automatic test_release();
    btn_up = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      logic [3:0] exp;
      tick();
      exp = {n < 6, 2'b00, (n < 6) || (n >= 14)};
      tests++;
      if ({up, left, right, enable} !== exp) begin
        fails++;
        $display("FAIL release n=%0d: got %b want %b", n, {up, left, right, enable}, exp);
      end
    end
  endtask

  task automatic test_staggered();
    btn_left = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      logic [3:0] exp;
      tick();
      exp = {1'b0, n >= 6, n >= 12, (n < 6) || (n >= 20)};
      tests++;
      if ({up, left, right, enable} !== exp) begin
        fails++;
        $display("FAIL staggered n=%0d: got %b want %b", n, {up, left, right, enable}, exp);
      end
      if (n == 6) btn_right = 1'b1;
    end
  endtask

  task automatic test_simultaneous();
    // Return to idle first so all three start from 0.
    btn_left = 1'b0; btn_right = 1'b0;
    for (int n = 1; n <= 14; n++) tick();
    tests++;
    if ({up, left, right, enable} !== 4'b0001) begin
      fails++;
      $display("FAIL simul_idle: got %b want 0001", {up, left, right, enable});
    end
    btn_up = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      logic [3:0] exp;
      tick();
      exp = {{3{n >= 6}}, (n < 6) || (n >= 14)};
      tests++;
      if ({up, left, right, enable} !== exp) begin
        fails++;
        $display("FAIL simul_press n=%0d: got %b want %b", n, {up, left, right, enable}, exp);
      end
    end
    btn_up = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      logic [3:0] exp;
      tick();
      exp = {{3{n < 6}}, (n < 6) || (n >= 14)};
      tests++;
      if ({up, left, right, enable} !== exp) begin
        fails++;
        $display("FAIL simul_release n=%0d: got %b want %b", n, {up, left, right, enable}, exp);
      end
    end
  endtask

  task automatic test_reset_debounce();
    btn_right = 1'b1;
    // Edges 0..3: s2 goes high after edge 1, count reaches 2 at edge 3.
    for (int n = 1; n <= 4; n++) tick();
    rst = 1'b1;
    #1;
    tests++;
    if ({up, left, right, enable} !== 4'b0000) begin
      fails++;
      $display("FAIL rstdeb_assert: got %b want 0000", {up, left, right, enable});
    end
    tick();
    rst = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      logic [3:0] exp;
      tick();
      exp = {2'b00, n >= 6, n >= 14};
      tests++;
      if ({up, left, right, enable} !== exp) begin
        fails++;
        $display("FAIL rstdeb n=%0d: got %b want %b", n, {up, left, right, enable}, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Outputs are 001 with enable high here; reset must clear them without a clock.
    #3;
    rst = 1'b1;
    btn_right = 1'b0;
    #1;
    tests++;
    if ({up, left, right, enable} !== 4'b0000) begin
      fails++;
      $display("FAIL rstmid_assert: got %b want 0000", {up, left, right, enable});
    end
    tick();
    rst = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      logic [3:0] exp;
      tick();
      exp = {3'b000, n >= 8};
      tests++;
      if ({up, left, right, enable} !== exp) begin
        fails++;
        $display("FAIL rstmid n=%0d: got %b want %b", n, {up, left, right, enable}, exp);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_staggered();
    test_simultaneous();
    test_reset_debounce();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
